// File: rtl/s_port_byte_rx_pkg.sv
// s_port_byte_rx_pkg: receiver state encoding shared by the byte receiver
package s_port_byte_rx_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} rx_state_t;
endpackage

// File: rtl/s_port_byte_rx_sync.sv
// s_port_sync: 2-flop synchronizer plus falling-edge detector for a serial input idling high
module s_port_sync (
  input  logic clk,
  input  logic reset,
  input  logic s_in,
  output logic s_sync,
  output logic fall
);
  logic s_meta, s_dly;
  logic [2:0] vld;
  always_ff @(posedge clk) begin
    if (reset) begin
      {s_meta, s_sync, s_dly} <= 3'b111;
      vld <= 3'b000;
    end else begin
      {s_meta, s_sync, s_dly} <= {s_in, s_meta, s_sync};
      vld <= {vld[1:0], 1'b1};
    end
  end
  // the reset-forced 1s are not real line samples, so a line already low at reset release must not look like a fall
  assign fall = vld[2] & s_dly & ~s_sync;
endmodule

// File: rtl/s_port_byte_rx.sv
// s_port_byte_rx: 8E1 serial byte receiver with parity and framing error flags
module s_port_byte_rx
  import s_port_byte_rx_pkg::*;
#(
  parameter logic [14:0] PERIOD_VALUE = 15'h43d1,
  parameter logic [14:0] HALF_VALUE   = PERIOD_VALUE >> 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       s_in,
  output logic [7:0] byte_out,
  output logic       byte_out_en,
  output logic       parity_err,
  output logic       frame_err
);
  rx_state_t   state, state_nxt;
  logic        s_sync, start_edge, parity;
  logic [14:0] bit_cnt;
  logic [2:0]  data_cnt;
  logic [7:0]  shift;
  logic        half_hit, per_hit;
  s_port_sync u_sync (
    .clk    (clk),
    .reset  (reset),
    .s_in   (s_in),
    .s_sync (s_sync),
    .fall   (start_edge)
  );
  assign half_hit = bit_cnt == HALF_VALUE;
  assign per_hit  = bit_cnt == PERIOD_VALUE;
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    state_nxt = start_edge ? START : IDLE;
      START:   state_nxt = half_hit ? (s_sync ? IDLE : DATA) : START;
      DATA:    state_nxt = (per_hit && data_cnt == 3'd7) ? PARITY : DATA;
      PARITY:  state_nxt = per_hit ? STOP : PARITY;
      STOP:    state_nxt = per_hit ? IDLE : STOP;
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      data_cnt    <= '0;
      shift       <= '0;
      parity      <= 1'b0;
      byte_out    <= '0;
      byte_out_en <= 1'b0;
      parity_err  <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      state       <= state_nxt;
      byte_out_en <= 1'b0;
      // wrapping at PERIOD_VALUE keeps consecutive data bits one period apart
      bit_cnt <= (state == IDLE || state_nxt != state || per_hit) ? '0 : bit_cnt + 15'd1;
      if (state == DATA && per_hit) begin
        shift    <= {s_sync, shift[7:1]};
        data_cnt <= data_cnt + 3'd1;
      end
      if (state == PARITY && per_hit) parity <= s_sync;
      if (state == STOP && per_hit) begin
        byte_out    <= shift;
        parity_err  <= (^shift) ^ parity;
        frame_err   <= ~s_sync;
        byte_out_en <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_s_port_byte_rx.sv
// tb_s_port_byte_rx: randomized and directed frames checked against a frame-level scoreboard
module tb_s_port_byte_rx;
  localparam logic [14:0] P = 15'd15;
  localparam int BIT = 16;
  localparam int LAT = 2 + (int'(P) >> 1) + 1 + 10 * BIT + 1;
  typedef struct {
    logic [7:0] d;
    logic       pe;
    logic       fe;
    int         at;
  } exp_t;
  logic       clk = 1'b0, reset = 1'b1, s_in = 1'b1;
  logic [7:0] byte_out;
  logic       byte_out_en, parity_err, frame_err;
  int         cyc = 0, n_cmp = 0, n_bad = 0;
  exp_t       q[$];
  s_port_byte_rx #(.PERIOD_VALUE(P)) dut (
    .clk         (clk),
    .reset       (reset),
    .s_in        (s_in),
    .byte_out    (byte_out),
    .byte_out_en (byte_out_en),
    .parity_err  (parity_err),
    .frame_err   (frame_err)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask
  task automatic idle(input int n, input logic v);
    s_in = v;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic send(input logic [7:0] d, input bit bad_par, input bit bad_stop);
    logic p;
    exp_t e;
    p = (^d) ^ bad_par;
    e.d  = d;
    e.pe = (($countones(d) + int'(p)) % 2) == 1;
    e.fe = bad_stop;
    e.at = cyc + LAT;
    q.push_back(e);
    idle(BIT, 1'b0);
    for (int k = 0; k < 8; k++) idle(BIT, d[k]);
    idle(BIT, p);
    idle(BIT, !bad_stop);
  endtask
  always @(negedge clk) begin
    if (!reset && byte_out_en) begin
      if (q.size() == 0) chk("spurious_strobe", 32'd1, 32'd0);
      else begin
        exp_t e;
        e = q.pop_front();
        chk("byte_out", byte_out, e.d);
        chk("parity_err", parity_err, e.pe);
        chk("frame_err", frame_err, e.fe);
        chk("strobe_cycle", cyc, e.at);
      end
    end
  end
  initial begin
    idle(4, 1'b1);
    chk("rst_byte_out", byte_out, 8'h00);
    chk("rst_en", byte_out_en, 1'b0);
    chk("rst_perr", parity_err, 1'b0);
    chk("rst_ferr", frame_err, 1'b0);
    reset = 1'b0;
    idle(20, 1'b1);
    send(8'hA5, 0, 0);
    idle(10, 1'b1);
    send(8'h01, 1, 0);
    idle(10, 1'b1);
    send(8'h3C, 0, 1);
    idle(40 * BIT, 1'b0);
    idle(32, 1'b1);
    idle(4, 1'b0);
    idle(6, 1'b1);
    send(8'h96, 0, 0);
    idle(20, 1'b1);
    idle(BIT, 1'b0);
    idle(4 * BIT + 8, 1'b0);
    reset = 1'b1;
    idle(3, 1'b0);
    reset = 1'b0;
    idle(60, 1'b0);
    chk("reset_byte_out", byte_out, 8'h00);
    chk("reset_en", byte_out_en, 1'b0);
    idle(40, 1'b1);
    send(8'hFF, 0, 0);
    send(8'h00, 0, 0);
    send(8'h55, 0, 0);
    send(8'hAA, 0, 0);
    send(8'hFF, 0, 0);
    for (int i = 0; i < 24; i++) begin
      bit bp, bs;
      int gap;
      bp  = $urandom_range(0, 4) == 0;
      bs  = $urandom_range(0, 5) == 0;
      gap = bs ? $urandom_range(2, 30) : $urandom_range(0, 30);
      send(8'($urandom), bp, bs);
      if (gap > 0) idle(gap, 1'b1);
    end
    idle(400, 1'b1);
    chk("pending_frames", q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
